// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline stage: entry-count state and occupancy width.
package pipe_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_data_reg.sv
// Enable-gated payload register with asynchronous active-low reset to a fixed value.
module pipe_data_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline register: single-entry (SKID=0) or 2-entry skid buffer
// with registered in_ready (SKID=1), plus synchronous flush.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SKID      = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             emit;
    logic             main_en;
    logic             skid_en;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;

    assign out_valid = (state == ONE) || (state == FULL);
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;
    assign main_d    = (state == FULL) ? skid_q : in_data;

    always_comb begin
        state_nxt = EMPTY;
        main_en   = 1'b0;
        skid_en   = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = ONE;
                    main_en   = 1'b1;
                end
            end
            ONE: begin
                state_nxt = ONE;
                if (accept && (emit || !SKID)) begin
                    main_en = 1'b1;
                end else if (accept) begin
                    state_nxt = FULL;
                    skid_en   = 1'b1;
                end else if (emit) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                state_nxt = FULL;
                if (emit) begin
                    state_nxt = ONE;
                    main_en   = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Squash wins over everything; payload registers are left stale, not cleared.
        if (flush) begin
            state_nxt = EMPTY;
            main_en   = 1'b0;
            skid_en   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        case (state)
            ONE:     occupancy = OCC_W'(1);
            FULL:    occupancy = OCC_W'(2);
            default: occupancy = OCC_W'(0);
        endcase
    end

    pipe_data_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk (clk),
        .rst (rst),
        .en  (main_en),
        .d   (main_d),
        .q   (out_data)
    );

    generate
        if (SKID) begin : g_skid
            logic in_ready_q;

            // Registered ready: upstream never sees a combinational path from out_ready.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    in_ready_q <= 1'b0;
                end else begin
                    in_ready_q <= (state_nxt != FULL);
                end
            end

            assign in_ready = in_ready_q;

            pipe_data_reg #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_skid (
                .clk (clk),
                .rst (rst),
                .en  (skid_en),
                .d   (in_data),
                .q   (skid_q)
            );
        end else begin : g_noskid
            assign in_ready = rst && (out_ready || !out_valid);
            assign skid_q   = RESET_VAL;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a SKID=1 instance (32-bit) and a SKID=0 instance (8-bit).
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        a_flush = 1'b0;
    logic        a_in_valid = 1'b0;
    logic        a_in_ready;
    logic [31:0] a_in_data = '0;
    logic        a_out_valid;
    logic        a_out_ready = 1'b0;
    logic [31:0] a_out_data;
    logic [1:0]  a_occ;

    logic        b_flush = 1'b0;
    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [7:0]  b_in_data = '0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b0;
    logic [7:0]  b_out_data;
    logic [1:0]  b_occ;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [31:0] want_q[$];
    logic        a_last_acc;

    localparam logic [31:0] A_RST = 32'h0000_00C3;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(32), .RESET_VAL(A_RST), .SKID(1'b1)) u_a (
        .clk       (clk),
        .rst       (rst),
        .flush     (a_flush),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .occupancy (a_occ)
    );

    pipe_stage_reg #(.WIDTH(8), .RESET_VAL(8'hFF), .SKID(1'b0)) u_b (
        .clk       (clk),
        .rst       (rst),
        .flush     (b_flush),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .occupancy (b_occ)
    );

    // One clock of the SKID=1 instance: records accepts and emits, no judging here.
    task automatic step_a();
        logic acc;
        logic emt;
        @(negedge clk);
        acc = a_in_valid && a_in_ready;
        emt = a_out_valid && a_out_ready;
        if (emt) begin
            got_q.push_back(a_out_data);
            if (exp_q.size() > 0) want_q.push_back(exp_q.pop_front());
            else want_q.push_back('x);
        end
        if (a_flush) exp_q.delete();
        else if (acc) exp_q.push_back(a_in_data);
        a_last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        a_in_valid = 1'b1;
        a_in_data = 32'h1234;
        b_in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL rst_a_out_valid got=%b want=0", a_out_valid); end
        total++; if (a_out_data !== A_RST) begin bad++; $display("FAIL rst_a_out_data got=%h want=%h", a_out_data, A_RST); end
        total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL rst_a_in_ready got=%b want=0", a_in_ready); end
        total++; if (a_occ !== 2'd0) begin bad++; $display("FAIL rst_a_occ got=%0d want=0", a_occ); end
        total++; if (b_out_data !== 8'hFF) begin bad++; $display("FAIL rst_b_out_data got=%h want=ff", b_out_data); end
        total++; if (b_in_ready !== 1'b0) begin bad++; $display("FAIL rst_b_in_ready got=%b want=0", b_in_ready); end
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        rst = 1'b1;
        #1;
        total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL rel_a_in_ready_early got=%b want=0", a_in_ready); end
        @(posedge clk);
        #1;
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL rel_a_in_ready got=%b want=1", a_in_ready); end
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL rel_a_out_valid got=%b want=0", a_out_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] g;
        logic [31:0] w;
        int n;
        got_q.delete(); want_q.delete(); exp_q.delete();
        a_out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            a_in_valid = 1'b1;
            a_in_data = 32'(i);
            step_a();
            total++;
            if (a_out_valid !== 1'b1 || a_out_data !== 32'(i)) begin
                bad++;
                $display("FAIL stream_latency i=%0d got_valid=%b got_data=%h want_data=%h", i, a_out_valid, a_out_data, 32'(i));
            end
            total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready i=%0d got=%b want=1", i, a_in_ready); end
        end
        a_in_valid = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) step_a();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stream_drain left=%0d want=0", exp_q.size()); end
        n = got_q.size();
        total++; if (n != 16) begin bad++; $display("FAIL stream_count got=%0d want=16", n); end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            w = want_q.pop_front();
            total++; if (g !== w) begin bad++; $display("FAIL stream_order got=%h want=%h", g, w); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] g;
        logic [31:0] w;
        int k;
        got_q.delete(); want_q.delete(); exp_q.delete();
        a_out_ready = 1'b0;
        a_in_valid = 1'b1;
        a_in_data = 32'hA; step_a();
        a_in_data = 32'hB; step_a();
        total++; if (a_occ !== 2'd2) begin bad++; $display("FAIL bp_occ got=%0d want=2", a_occ); end
        total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", a_in_ready); end
        a_in_data = 32'hC; step_a();
        total++; if (a_last_acc !== 1'b0) begin bad++; $display("FAIL bp_c_held got=%b want=0", a_last_acc); end
        total++; if (a_out_data !== 32'hA) begin bad++; $display("FAIL bp_head got=%h want=a", a_out_data); end
        a_out_ready = 1'b1;
        k = 0;
        do begin step_a(); k++; end while (!a_last_acc && k < 10);
        a_in_valid = 1'b0;
        total++; if (!a_last_acc) begin bad++; $display("FAIL bp_c_accept_timeout got=0 want=1"); end
        for (int j = 0; j < 10 && exp_q.size() > 0; j++) step_a();
        total++; if (got_q.size() != 3) begin bad++; $display("FAIL bp_count got=%0d want=3", got_q.size()); end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            w = want_q.pop_front();
            total++; if (g !== w) begin bad++; $display("FAIL bp_order got=%h want=%h", g, w); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] g;
        logic [31:0] w;
        got_q.delete(); want_q.delete(); exp_q.delete();
        a_out_ready = 1'b0;
        a_in_valid = 1'b1;
        a_in_data = 32'hA; step_a();
        a_in_data = 32'hB; step_a();
        a_flush = 1'b1;
        a_in_data = 32'hD; step_a();
        a_flush = 1'b0;
        a_in_valid = 1'b0;
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b want=0", a_out_valid); end
        total++; if (a_occ !== 2'd0) begin bad++; $display("FAIL flush_occ got=%0d want=0", a_occ); end
        total++; if (a_out_data !== 32'hA) begin bad++; $display("FAIL flush_stale_data got=%h want=a", a_out_data); end
        a_out_ready = 1'b1;
        repeat (4) step_a();
        a_in_valid = 1'b1;
        a_in_data = 32'hE; step_a();
        a_in_valid = 1'b0;
        a_flush = 1'b1; step_a();
        a_flush = 1'b0;
        repeat (3) step_a();
        total++; if (got_q.size() != 1) begin bad++; $display("FAIL flush_emit_count got=%0d want=1", got_q.size()); end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            w = want_q.pop_front();
            total++; if (g !== w) begin bad++; $display("FAIL flush_emit got=%h want=%h", g, w); end
        end
    endtask

    task automatic test_skid0();
        b_out_ready = 1'b0;
        b_in_valid = 1'b1;
        b_in_data = 8'h11;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        total++; if (b_out_valid !== 1'b1 || b_out_data !== 8'h11) begin bad++; $display("FAIL s0_load got_valid=%b got_data=%h want=11", b_out_valid, b_out_data); end
        total++; if (b_occ !== 2'd1) begin bad++; $display("FAIL s0_occ got=%0d want=1", b_occ); end
        total++; if (b_in_ready !== 1'b0) begin bad++; $display("FAIL s0_ready_low got=%b want=0", b_in_ready); end
        b_out_ready = 1'b1; #1;
        total++; if (b_in_ready !== 1'b1) begin bad++; $display("FAIL s0_ready_follow got=%b want=1", b_in_ready); end
        b_out_ready = 1'b0; #1;
        total++; if (b_in_ready !== 1'b0) begin bad++; $display("FAIL s0_ready_drop got=%b want=0", b_in_ready); end
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (b_out_valid !== 1'b0 || b_occ !== 2'd0) begin bad++; $display("FAIL s0_emit_empty got_valid=%b got_occ=%0d want=0", b_out_valid, b_occ); end
        total++; if (b_in_ready !== 1'b1) begin bad++; $display("FAIL s0_ready_empty got=%b want=1", b_in_ready); end
    endtask

    task automatic test_async_reset();
        exp_q.delete(); got_q.delete(); want_q.delete();
        a_out_ready = 1'b0;
        a_in_valid = 1'b1;
        a_in_data = 32'h55; step_a();
        a_in_data = 32'h66; step_a();
        a_in_valid = 1'b0;
        total++; if (a_occ !== 2'd2) begin bad++; $display("FAIL ar_pre_occ got=%0d want=2", a_occ); end
        #2 rst = 1'b0;
        #1;
        total++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin bad++; $display("FAIL ar_state got_valid=%b got_occ=%0d want=0", a_out_valid, a_occ); end
        total++; if (a_out_data !== A_RST) begin bad++; $display("FAIL ar_data got=%h want=%h", a_out_data, A_RST); end
        total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL ar_in_ready got=%b want=0", a_in_ready); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin bad++; $display("FAIL ar_release got_ready=%b got_valid=%b", a_in_ready, a_out_valid); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_skid0();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
